// File: rtl/inst_mem_ctrl.sv
// -----------------------------------------------------------------------------
// inst_mem_ctrl
//   Instruction-memory responder for the IF_Stage fetch port. A fetch that
//   misses the one-word last-fetch buffer takes LATENCY cycles from the accept
//   edge to the ready pulse. A fetch that hits the buffer takes one cycle.
//   stall holds the PC and IF/ID register while a request waits for ready.
//   The program port writes the array at any time and never stalls fetches.
//
// Handshake: req is raised with addr stable and held until the cycle in which
//   ready pulses. inst is valid only in that cycle. flush abandons the fetch
//   at the next edge without a ready pulse.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   req        in   fetch request
//   addr       in   byte address of the fetch (word index = addr[31:2])
//   flush      in   abandon any in-flight fetch
//   ready      out  one-cycle completion pulse (registered)
//   inst       out  fetched instruction (registered)
//   stall      out  req & ~ready
//   prog_we    in   program-port write enable
//   prog_addr  in   program-port byte address
//   prog_data  in   program-port write data
//   dbg_state  out  FSM state: 0 IDLE, 1 BUSY, 2 RESP
// -----------------------------------------------------------------------------
module inst_mem_ctrl #(
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 4,
    parameter logic [31:0] NOP     = 32'hE1A00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        flush,
    output logic        ready,
    output logic [31:0] inst,
    output logic        stall,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data,
    output logic [1:0]  dbg_state
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [29:0] DEPTH_W = 30'(DEPTH);
    localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);
    localparam bit          LAT_ONE = (LATENCY == 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [29:0] pend_q;
    logic [29:0] buf_addr_q;
    logic [31:0] buf_data_q;
    logic        buf_valid_q;
    logic        ready_q;
    logic [31:0] inst_q;

    logic [31:0] mem [DEPTH];

    logic [29:0] req_idx;
    logic [29:0] prog_idx;
    logic [29:0] rd_idx;
    logic        rd_in_range;
    logic [31:0] rd_word;
    logic        accept;
    logic        hit;
    logic        complete;

    // Address LSBs select bytes within a word and are not used.
    logic unused_lsbs;
    assign unused_lsbs = ^{addr[1:0], prog_addr[1:0]};

    assign req_idx  = addr[31:2];
    assign prog_idx = prog_addr[31:2];

    // A same-edge program write invalidates the buffer, so it also kills a hit.
    assign hit    = buf_valid_q && (req_idx == buf_addr_q) && !prog_we;
    assign accept = (state_q == IDLE) && req && !flush;

    // The array is read on the completion edge: the accept edge when
    // LATENCY is 1, otherwise the last BUSY edge. Reading late lets a write to
    // the pending index made during BUSY reach this fetch.
    assign rd_idx      = (state_q == IDLE) ? req_idx : pend_q;
    assign rd_in_range = (rd_idx < DEPTH_W);
    assign rd_word     = rd_in_range ? mem[rd_idx[AW-1:0]] : NOP;
    assign complete    = ((state_q == BUSY) && (cnt_q == 4'd1) && !flush) ||
                         (accept && !hit && LAT_ONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (hit || LAT_ONE) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            pend_q      <= 30'd0;
            buf_addr_q  <= 30'd0;
            buf_data_q  <= 32'd0;
            buf_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            inst_q      <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == RESP);
            if (accept) begin
                pend_q <= req_idx;
            end
            if (state_d == RESP) begin
                inst_q <= (accept && hit) ? buf_data_q : rd_word;
            end
            // Any program write invalidates the buffer, even one that lands
            // on the same edge as a miss completion.
            if (prog_we) begin
                buf_valid_q <= 1'b0;
            end else if (complete && rd_in_range) begin
                buf_valid_q <= 1'b1;
                buf_addr_q  <= rd_idx;
                buf_data_q  <= rd_word;
            end
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (prog_we && (prog_idx < DEPTH_W)) begin
            mem[prog_idx[AW-1:0]] <= prog_data;
        end
    end

    assign ready     = ready_q;
    assign inst      = inst_q;
    assign stall     = req && !ready_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
module tb_inst_mem_ctrl;

  localparam int          DEPTH = 1024;
  localparam int          LAT   = 4;
  localparam logic [31:0] NOP   = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, flush, prog_we;
  logic [31:0] addr, prog_addr, prog_data;
  logic        ready, stall;
  logic [31:0] inst;
  logic [1:0]  dbg_state;

  logic        req1, flush1, prog_we1;
  logic [31:0] addr1, prog_addr1, prog_data1;
  logic        ready1, stall1;
  logic [31:0] inst1;
  logic [1:0]  dbg_state1;

  int checks = 0;
  int errors = 0;

  // behavioural model: array image plus last-fetch buffer
  logic [31:0] mdl_mem [0:DEPTH-1];
  bit          b_valid;
  logic [29:0] b_addr;
  logic [31:0] b_data;

  always #5 clk = ~clk;

  inst_mem_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT), .NOP(NOP)) u_dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .flush(flush),
    .ready(ready), .inst(inst), .stall(stall), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .dbg_state(dbg_state)
  );

  inst_mem_ctrl #(.DEPTH(16), .LATENCY(1), .NOP(NOP)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .addr(addr1), .flush(flush1),
    .ready(ready1), .inst(inst1), .stall(stall1), .prog_we(prog_we1),
    .prog_addr(prog_addr1), .prog_data(prog_data1), .dbg_state(dbg_state1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit mdl_hit(input logic [31:0] a);
    return b_valid && (a[31:2] == b_addr);
  endfunction

  task automatic mdl_write(input logic [31:0] wa, input logic [31:0] wd);
    if (wa[31:2] < 30'(DEPTH)) mdl_mem[wa[31:2]] = wd;
    b_valid = 0;
  endtask

  // called at a negedge; returns at a negedge
  task automatic prog_write(input logic [31:0] wa, input logic [31:0] wd);
    prog_we = 1; prog_addr = wa; prog_data = wd;
    @(negedge clk);
    prog_we = 0;
    mdl_write(wa, wd);
  endtask

  // mode 0: plain fetch; 1: flush raised in cycle k; 2: program write in cycle k
  task automatic do_fetch(input string tag, input logic [31:0] a, input int mode, input int k,
                          input logic [31:0] wa, input logic [31:0] wd);
    bit          m_hit;
    int          exp_lat, lat, c;
    logic [31:0] exp_inst, got;
    logic [29:0] idx;
    bit          stall_ok;
    idx = a[31:2];
    m_hit = mdl_hit(a) && !(mode == 2 && k == 0);
    exp_lat = m_hit ? 1 : LAT;
    lat = 0; c = 0; got = '0; stall_ok = 1;
    req = 1; addr = a;
    if (mode == 2 && k == 0) begin
      prog_we = 1; prog_addr = wa; prog_data = wd;
      mdl_write(wa, wd);
    end
    #1;
    if (stall !== 1'b1) stall_ok = 0;
    while (lat == 0 && c < 20 && !(mode == 1 && c == k + 1)) begin
      @(negedge clk);
      c++;
      if (mode == 2 && c == k + 1) prog_we = 0;
      if (ready === 1'b1) begin
        lat = c; got = inst;
        chk({tag, "_stall_at_ready"}, 32'(stall), 32'd0);
      end else if (stall !== 1'b1) begin
        stall_ok = 0;
      end
      if (mode == 1 && c == k) flush = 1;
      if (mode == 2 && k > 0 && c == k) begin
        prog_we = 1; prog_addr = wa; prog_data = wd;
        mdl_write(wa, wd);
      end
    end
    req = 0; flush = 0; prog_we = 0;
    chk({tag, "_stall_while_waiting"}, 32'(stall_ok), 32'd1);
    if (mode == 1) begin
      chk({tag, "_flush_no_ready"}, 32'(lat), 32'd0);
      chk({tag, "_flush_idle"}, 32'(dbg_state), 32'd0);
      @(negedge clk);
      chk({tag, "_flush_ready_low"}, 32'(ready), 32'd0);
    end else begin
      if (m_hit) begin
        exp_inst = b_data;
      end else begin
        exp_inst = (idx < 30'(DEPTH)) ? mdl_mem[idx] : NOP;
        if (idx < 30'(DEPTH)) begin
          b_valid = 1; b_addr = idx; b_data = exp_inst;
        end
      end
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_inst"}, got, exp_inst);
      @(negedge clk);
      chk({tag, "_ready_pulse"}, 32'(ready), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] w, a;
    int r;
    rst = 0; req = 0; flush = 0; prog_we = 0; addr = 0; prog_addr = 0; prog_data = 0;
    req1 = 0; flush1 = 0; prog_we1 = 0; addr1 = 0; prog_addr1 = 0; prog_data1 = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    repeat (2) @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd0);
    chk("reset_inst", inst, 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);
    rst = 1;
    @(negedge clk);

    prog_write(32'hC, 32'hE3A01005);
    prog_write(32'h10, 32'hE2811001);
    prog_write(32'h14, 32'h11111111);
    prog_write(32'hFFC, 32'hDEADBEEF);

    // reset asserted in the middle of a miss
    req = 1; addr = 32'hC;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_mid_ready", 32'(ready), 32'd0);
    chk("rst_mid_state", 32'(dbg_state), 32'd0);
    chk("rst_mid_inst", inst, 32'd0);
    @(negedge clk);
    req = 0; rst = 1;
    b_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_release_ready", 32'(ready), 32'd0);
    end

    do_fetch("miss_c", 32'hC, 0, 0, 0, 0);
    do_fetch("hit_c", 32'hC, 0, 0, 0, 0);
    do_fetch("miss_10", 32'h10, 0, 0, 0, 0);
    do_fetch("miss_c2", 32'hC, 0, 0, 0, 0);
    do_fetch("flush_10", 32'h10, 1, 2, 0, 0);
    do_fetch("hit_after_flush", 32'hC, 0, 0, 0, 0);
    prog_write(32'hC, 32'hEAFFFFFE);
    do_fetch("miss_after_write", 32'hC, 0, 0, 0, 0);
    do_fetch("write_pending", 32'h14, 2, 2, 32'h14, 32'h5A5A0014);
    do_fetch("write_vs_hit", 32'h14, 2, 0, 32'h20, 32'h00000020);
    do_fetch("oor_1", 32'h1000, 0, 0, 0, 0);
    do_fetch("oor_2", 32'h1000, 0, 0, 0, 0);
    prog_write(32'h1000, 32'h12345678);
    do_fetch("oor_write_ignored", 32'h1000, 0, 0, 0, 0);
    do_fetch("last_word", 32'hFFF, 0, 0, 0, 0);
    do_fetch("last_word_hit", 32'hFFC, 0, 0, 0, 0);

    // randomized phase over a small, fully written index range
    for (int i = 0; i < 16; i++) prog_write(32'(i * 4), $urandom);
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, 3) * 4) | 32'($urandom_range(0, 3));
      w = $urandom;
      case (r)
        0, 1: prog_write(32'($urandom_range(0, 15) * 4), w);
        2: if (mdl_hit(a)) do_fetch("rnd_hit", a, 0, 0, 0, 0);
           else do_fetch("rnd_flush", a, 1, $urandom_range(1, 3), 0, 0);
        3: do_fetch("rnd_oor", 32'h1000 + 32'($urandom_range(0, 255) * 4), 0, 0, 0, 0);
        4: if (mdl_hit(a)) do_fetch("rnd_hit2", a, 0, 0, 0, 0);
           else do_fetch("rnd_wr_busy", a, 2, 2, a, w);
        default: do_fetch("rnd_fetch", a, 0, 0, 0, 0);
      endcase
    end

    // LATENCY=1 build: misses and hits both answer in cycle 1
    prog_we1 = 1; prog_addr1 = 32'h8; prog_data1 = 32'hCAFE0008;
    @(negedge clk);
    prog_we1 = 0;
    req1 = 1; addr1 = 32'h8;
    @(negedge clk);
    chk("lat1_miss_ready", 32'(ready1), 32'd1);
    chk("lat1_miss_inst", inst1, 32'hCAFE0008);
    req1 = 0;
    @(negedge clk);
    req1 = 1;
    @(negedge clk);
    chk("lat1_hit_ready", 32'(ready1), 32'd1);
    chk("lat1_hit_inst", inst1, 32'hCAFE0008);
    req1 = 0;
    @(negedge clk);
    req1 = 1; addr1 = 32'h40;
    @(negedge clk);
    chk("lat1_oor_ready", 32'(ready1), 32'd1);
    chk("lat1_oor_inst", inst1, NOP);
    req1 = 0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
